// File: rtl/dpi_stream_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dpi_stream_sequencer_if
// Description : Bundles the packet-ingress handshake and the matcher-facing
//               control/data bus of the DPI stream sequencer.
//               slave  - the sequencer side (consumes packets, drives matcher)
//               master - the packet source / matcher observer side
//   pkt_data/pkt_vld/pkt_sop/pkt_eop/pkt_key : packet byte stream in
//   pkt_rdy                                  : sequencer ready for a byte
//   char_in/char_in_vld                      : byte to the matcher
//   load_state/stream_id/new_stream_id       : matcher state-restore control
//   eop/enable                               : end-of-packet and stream enable
// Revision    : 1.0 - initial release
// ============================================================================
interface dpi_stream_sequencer_if;
    logic [7:0]  pkt_data;
    logic        pkt_vld;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [15:0] pkt_key;
    logic        pkt_rdy;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        load_state;
    logic [5:0]  stream_id;
    logic        new_stream_id;
    logic        eop;
    logic        enable;

    modport slave (
        input  pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_key,
        output pkt_rdy, char_in, char_in_vld, load_state, stream_id,
               new_stream_id, eop, enable
    );

    modport master (
        output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_key,
        input  pkt_rdy, char_in, char_in_vld, load_state, stream_id,
               new_stream_id, eop, enable
    );
endinterface
`default_nettype wire

// File: rtl/dpi_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dpi_stream_sequencer
// Description : Sequences a packet byte stream into a stateful matcher. Each
//               packet's flow key is looked up in a 64-entry flow table
//               (round-robin allocation/eviction on a miss); the matcher is
//               told to restore state (load_state), fed the bytes
//               (char_in/char_in_vld) and finally given an eop pulse with the
//               per-stream enable.
// Ports       : clk, rst (async, active-high), enable_mask[63:0],
//               bus (dpi_stream_sequencer_if.slave),
//               pkt_count/new_flow_count [15:0] (only with DPI_SEQ_STATS_EN)
// Parameters  : LOAD_GAP  (>=1, <256) idle cycles between load_state and the
//                         first char_in_vld
//               EOP_DRAIN (>=1, <256) cycles between the last char_in_vld
//                         and eop
// Options     : `define DPI_SEQ_STATS_EN to add the statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module dpi_stream_sequencer #(
    parameter int LOAD_GAP  = 2,
    parameter int EOP_DRAIN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [63:0]            enable_mask,
    dpi_stream_sequencer_if.slave  bus
`ifdef DPI_SEQ_STATS_EN
    ,
    output logic [15:0]            pkt_count,
    output logic [15:0]            new_flow_count
`endif
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LOOKUP = 3'd1;
    localparam logic [2:0] c_ST_LOAD   = 3'd2;
    localparam logic [2:0] c_ST_GAP    = 3'd3;
    localparam logic [2:0] c_ST_STREAM = 3'd4;
    localparam logic [2:0] c_ST_DRAIN  = 3'd5;
    localparam logic [2:0] c_ST_EOP    = 3'd6;

    localparam logic [7:0] c_GAP_LAST   = 8'(LOAD_GAP - 1);
    localparam logic [7:0] c_DRAIN_LAST = 8'(EOP_DRAIN - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;

    logic [15:0] r_key_tbl [64];
    logic [63:0] r_valid;
    logic [5:0]  r_alloc_ptr;
    logic [5:0]  r_stream_id;
    logic        r_new_id;

    logic [15:0] r_key;
    logic [7:0]  r_sop_byte;
    logic        r_sop_eop;
    logic [7:0]  r_char;
    logic        r_char_vld;
    logic [7:0]  r_cnt;
    logic        r_rdy_en;

    logic        w_hit;
    logic [5:0]  w_hit_idx;
    logic        w_sop_in_stream;
    logic        w_pkt_rdy;
    logic        w_xfer;
    logic        w_cnt_done;
    logic        w_miss;

    // A new SOP seen while streaming closes the current packet; the byte is
    // held off (ready low) so it is taken again from IDLE.
    assign w_sop_in_stream = (r_state == c_ST_STREAM) & bus.pkt_vld & bus.pkt_sop;
    // r_rdy_en keeps ready low while reset is applied and for the first
    // cycle after release.
    assign w_pkt_rdy = r_rdy_en & ((r_state == c_ST_IDLE) |
                                   ((r_state == c_ST_STREAM) & ~w_sop_in_stream));
    assign w_xfer     = bus.pkt_vld & w_pkt_rdy;
    assign w_cnt_done = ((r_state == c_ST_GAP)   & (r_cnt == c_GAP_LAST)) |
                        ((r_state == c_ST_DRAIN) & (r_cnt == c_DRAIN_LAST));
    assign w_miss     = (r_state == c_ST_LOOKUP) & ~w_hit;

    // Lowest matching valid index wins: scan downward so the last hit kept
    // is the smallest index.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (r_valid[i] && (r_key_tbl[i] == r_key)) begin
                w_hit     = 1'b1;
                w_hit_idx = 6'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_xfer && bus.pkt_sop) w_state_nxt = c_ST_LOOKUP;
            c_ST_LOOKUP: w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:   w_state_nxt = c_ST_GAP;
            c_ST_GAP:    if (w_cnt_done) w_state_nxt = r_sop_eop ? c_ST_DRAIN : c_ST_STREAM;
            c_ST_STREAM: if (w_sop_in_stream || (w_xfer && bus.pkt_eop)) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN:  if (w_cnt_done) w_state_nxt = c_ST_EOP;
            c_ST_EOP:    w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_alloc_ptr <= '0;
            r_stream_id <= '0;
            r_new_id    <= 1'b0;
            r_key       <= '0;
            r_sop_byte  <= '0;
            r_sop_eop   <= 1'b0;
            r_char      <= '0;
            r_char_vld  <= 1'b0;
            r_cnt       <= '0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_rdy_en   <= 1'b1;
            r_char_vld <= 1'b0;

            if ((r_state == c_ST_IDLE) && w_xfer && bus.pkt_sop) begin
                r_key      <= bus.pkt_key;
                r_sop_byte <= bus.pkt_data;
                r_sop_eop  <= bus.pkt_eop;
            end

            if (r_state == c_ST_LOOKUP) begin
                if (w_hit) begin
                    r_stream_id <= w_hit_idx;
                    r_new_id    <= 1'b0;
                end else begin
                    // A full table simply overwrites the entry at alloc_ptr.
                    r_stream_id          <= r_alloc_ptr;
                    r_new_id             <= 1'b1;
                    r_valid[r_alloc_ptr] <= 1'b1;
                    r_alloc_ptr          <= r_alloc_ptr + 6'd1;
                end
            end

            // One counter serves both GAP and DRAIN; it is zero on entry.
            if (((r_state == c_ST_GAP) || (r_state == c_ST_DRAIN)) && !w_cnt_done)
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;

            if ((r_state == c_ST_GAP) && w_cnt_done) begin
                r_char     <= r_sop_byte;
                r_char_vld <= 1'b1;
            end else if ((r_state == c_ST_STREAM) && w_xfer) begin
                r_char     <= bus.pkt_data;
                r_char_vld <= 1'b1;
            end
        end
    end

    // Keys need no reset: the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_miss) r_key_tbl[r_alloc_ptr] <= r_key;
    end

`ifdef DPI_SEQ_STATS_EN
    logic [15:0] r_pkt_count;
    logic [15:0] r_new_flow_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count      <= '0;
            r_new_flow_count <= '0;
        end else begin
            if (r_state == c_ST_EOP) r_pkt_count      <= r_pkt_count + 16'd1;
            if (w_miss)              r_new_flow_count <= r_new_flow_count + 16'd1;
        end
    end

    assign pkt_count      = r_pkt_count;
    assign new_flow_count = r_new_flow_count;
`endif

    assign bus.pkt_rdy       = w_pkt_rdy;
    assign bus.char_in       = r_char;
    assign bus.char_in_vld   = r_char_vld;
    assign bus.load_state    = (r_state == c_ST_LOAD);
    assign bus.stream_id     = r_stream_id;
    assign bus.new_stream_id = r_new_id;
    assign bus.eop           = (r_state == c_ST_EOP);
    assign bus.enable        = (r_state == c_ST_EOP) & enable_mask[r_stream_id];

endmodule
`default_nettype wire

// File: tb/tb_dpi_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpi_stream_sequencer
// Description : Directed self-checking bench for dpi_stream_sequencer:
//               reset values, lookup hit/miss, pulse timing, multi-byte
//               streaming with enable, implicit eop on mid-packet SOP,
//               reset during streaming and flow-table wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpi_stream_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] enable_mask;

    dpi_stream_sequencer_if bus_if ();

`ifdef DPI_SEQ_STATS_EN
    logic [15:0] pkt_count;
    logic [15:0] new_flow_count;
`endif

    dpi_stream_sequencer #(.LOAD_GAP(2), .EOP_DRAIN(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_mask (enable_mask),
        .bus         (bus_if)
`ifdef DPI_SEQ_STATS_EN
        ,
        .pkt_count      (pkt_count),
        .new_flow_count (new_flow_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Event recorder, sampled 2 time units after each rising edge.
    int         cyc = 0;
    int         ld_cnt = 0, ld_cyc = 0, eop_cnt = 0, eop_cyc = 0, multi_cnt = 0;
    logic [5:0] ld_sid, eop_sid;
    logic       ld_new, eop_en;
    int         vld_cyc[$];
    logic [7:0] vld_dat[$];

    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus_if.load_state) begin
            ld_cnt++;
            ld_cyc = cyc;
            ld_sid = bus_if.stream_id;
            ld_new = bus_if.new_stream_id;
        end
        if (bus_if.char_in_vld) begin
            vld_cyc.push_back(cyc);
            vld_dat.push_back(bus_if.char_in);
        end
        if (bus_if.eop) begin
            eop_cnt++;
            eop_cyc = cyc;
            eop_sid = bus_if.stream_id;
            eop_en  = bus_if.enable;
        end
        if ((int'(bus_if.load_state) + int'(bus_if.char_in_vld) + int'(bus_if.eop)) > 1)
            multi_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_if.pkt_vld  = 1'b0;
        bus_if.pkt_sop  = 1'b0;
        bus_if.pkt_eop  = 1'b0;
        bus_if.pkt_data = 8'h00;
        bus_if.pkt_key  = 16'h0000;
    endtask

    task automatic send_bytes(input logic [15:0] key, input int len,
                              input logic [7:0] base, input bit last_eop);
        for (int i = 0; i < len; i++) begin
            int n = 0;
            bus_if.pkt_data = base + 8'(i);
            bus_if.pkt_sop  = (i == 0);
            bus_if.pkt_eop  = last_eop && (i == len - 1);
            bus_if.pkt_key  = key;
            bus_if.pkt_vld  = 1'b1;
            #1;
            while (!bus_if.pkt_rdy && n < 100) begin
                tick();
                n++;
            end
            chk("xfer_rdy", {31'd0, bus_if.pkt_rdy}, 32'd1);
            @(posedge clk);
            #1;
        end
        idle_bus();
    endtask

    task automatic wait_eop(input int start);
        int n = 0;
        while (eop_cnt == start && n < 60) begin
            tick();
            n++;
        end
        chk("eop_seen", eop_cnt, start + 1);
    endtask

    task automatic run_pkt(input string tag, input logic [15:0] key, input int len,
                           input logic [7:0] base, input logic [5:0] exp_sid,
                           input logic exp_new);
        int e0 = eop_cnt;
        int l0 = ld_cnt;
        vld_cyc.delete();
        vld_dat.delete();
        send_bytes(key, len, base, 1'b1);
        wait_eop(e0);
        chk({tag, "_ldcnt"},  ld_cnt, l0 + 1);
        chk({tag, "_sid"},    {26'd0, ld_sid}, {26'd0, exp_sid});
        chk({tag, "_new"},    {31'd0, ld_new}, {31'd0, exp_new});
        chk({tag, "_eopsid"}, {26'd0, eop_sid}, {26'd0, exp_sid});
        chk({tag, "_nvld"},   vld_cyc.size(), len);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  {31'd0, bus_if.pkt_rdy},       32'd0);
        chk({tag, "_chr"},  {24'd0, bus_if.char_in},       32'd0);
        chk({tag, "_vld"},  {31'd0, bus_if.char_in_vld},   32'd0);
        chk({tag, "_ld"},   {31'd0, bus_if.load_state},    32'd0);
        chk({tag, "_eop"},  {31'd0, bus_if.eop},           32'd0);
        chk({tag, "_sid"},  {26'd0, bus_if.stream_id},     32'd0);
        chk({tag, "_new"},  {31'd0, bus_if.new_stream_id}, 32'd0);
        chk({tag, "_en"},   {31'd0, bus_if.enable},        32'd0);
    endtask

    initial begin
        int e0;
        int l0;
        int n;

        rst = 1'b1;
        enable_mask = 64'h0;
        idle_bus();

        // Reset values while reset is held.
        #1;
        chk_all_zero("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rdy_after_rst", {31'd0, bus_if.pkt_rdy}, 32'd1);

        // Single-byte packet on an empty table: t, t+3, t+6.
        run_pkt("a", 16'h1234, 1, 8'hA5, 6'd0, 1'b1);
        chk("a_vld_lat", vld_cyc[0] - ld_cyc, 3);
        chk("a_eop_lat", eop_cyc - ld_cyc, 6);
        chk("a_data",    {24'd0, vld_dat[0]}, 32'hA5);
        chk("a_en",      {31'd0, eop_en}, 32'd0);

        // Same key again is a hit.
        run_pkt("b", 16'h1234, 1, 8'h11, 6'd0, 1'b0);

        // Fill entries 1..4 so the next new key lands on stream 5.
        for (int k = 1; k <= 4; k++)
            run_pkt("fill", 16'h2000 + 16'(k), 1, 8'(k), 6'(k), 1'b1);

        // Four-byte packet on stream 5 with its enable bit set.
        enable_mask = 64'h20;
        run_pkt("c", 16'h5555, 4, 8'h40, 6'd5, 1'b1);
        chk("c_first_lat", vld_cyc[0] - ld_cyc, 3);
        chk("c_contig",    vld_cyc[3] - vld_cyc[0], 3);
        for (int i = 0; i < 4; i++)
            chk("c_data", {24'd0, vld_dat[i]}, 32'h40 + i);
        chk("c_drain",     eop_cyc - vld_cyc[3], 3);
        chk("c_en",        {31'd0, eop_en}, 32'd1);

        // SOP arriving mid-packet closes the old packet first.
        e0 = eop_cnt;
        l0 = ld_cnt;
        vld_cyc.delete();
        vld_dat.delete();
        send_bytes(16'h7777, 2, 8'h60, 1'b0);
        chk("d_x_sid", {26'd0, ld_sid}, 32'd6);
        bus_if.pkt_data = 8'h99;
        bus_if.pkt_sop  = 1'b1;
        bus_if.pkt_eop  = 1'b1;
        bus_if.pkt_key  = 16'h8888;
        bus_if.pkt_vld  = 1'b1;
        #1;
        chk("d_rdy_low", {31'd0, bus_if.pkt_rdy}, 32'd0);
        n = 0;
        while (!bus_if.pkt_rdy && n < 100) begin
            tick();
            n++;
        end
        chk("d_eop_before", eop_cnt, e0 + 1);
        chk("d_x_nvld",     vld_cyc.size(), 2);
        chk("d_x_en",       {31'd0, eop_en}, 32'd0);
        @(posedge clk);
        #1;
        idle_bus();
        wait_eop(e0 + 1);
        chk("d_y_ldcnt", ld_cnt, l0 + 2);
        chk("d_y_sid",   {26'd0, ld_sid}, 32'd7);
        chk("d_y_new",   {31'd0, ld_new}, 32'd1);

        // Reset during STREAM: outputs drop at once and no eop follows.
        send_bytes(16'h9999, 2, 8'h70, 1'b0);
        e0 = eop_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("e");
        tick();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("e_no_eop", eop_cnt, e0);
        run_pkt("e_re", 16'h1234, 1, 8'h22, 6'd0, 1'b1);

        // Wrap-around: 64 keys fill the table, the 65th evicts entry 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 64; i++)
            run_pkt("w", 16'h1000 + 16'(i), 1, 8'(i), 6'(i), 1'b1);
        run_pkt("w65",    16'h1040, 1, 8'hC0, 6'd0, 1'b1);
        run_pkt("w_first", 16'h1000, 1, 8'hC1, 6'd1, 1'b1);
        run_pkt("w_hit",  16'h1002, 1, 8'hC2, 6'd2, 1'b0);

        chk("excl", multi_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
